// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: CPU writeback request and register-file write port bundle
interface regfile_write_arbiter_if;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    modport master (output wb_en, wb_addr, wb_data, input rf_we, rf_waddr, rf_wdata, stall_req);
    modport slave  (input wb_en, wb_addr, wb_data, output rf_we, rf_waddr, rf_wdata, stall_req);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: debounced button flags share the register-file write port with CPU writeback
module regfile_write_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_button,
    input  logic                   decision_button,
    input  logic                   out_button,
    regfile_write_arbiter_if.slave bus,
    output logic [2:0]             pending
);
    localparam logic [1:0] RELEASED    = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [2:0]    s1, s2, press, gnt;
    logic          wb_win, flag_win;
    logic [4:0]    faddr;
    logic [SW-1:0] starve;

    always_ff @(posedge clk)
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {out_button, decision_button, in_button};
            s2 <= s1;
        end

    genvar i;
    for (i = 0; i < 3; i++) begin : g_db
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        logic          done;
        assign done     = cnt >= CW'(DEBOUNCE_CYCLES - 1);
        assign press[i] = st == PRESS_CHK && s2[i] && done;
        always_ff @(posedge clk)
            if (!reset) begin
                st  <= RELEASED;
                cnt <= '0;
            end else
                case (st)
                    RELEASED:
                        if (s2[i]) begin
                            st  <= PRESS_CHK;
                            cnt <= CW'(1);
                        end
                    PRESS_CHK:
                        if (!s2[i] || done) begin
                            st  <= s2[i] ? PRESSED : RELEASED;
                            cnt <= '0;
                        end else
                            cnt <= cnt + CW'(1);
                    PRESSED:
                        if (!s2[i]) begin
                            st  <= RELEASE_CHK;
                            cnt <= CW'(1);
                        end
                    default:
                        if (s2[i] || done) begin
                            st  <= s2[i] ? PRESSED : RELEASED;
                            cnt <= '0;
                        end else
                            cnt <= cnt + CW'(1);
                endcase
    end

    // A zero-address writeback never wins, leaving the port free for a flag.
    assign wb_win   = !bus.stall_req && bus.wb_en && bus.wb_addr != 5'd0;
    assign flag_win = !wb_win && |pending;
    assign gnt      = flag_win ? (pending & (~pending + 3'd1)) : 3'b000;
    assign faddr    = pending[0] ? 5'd22 : pending[1] ? 5'd23 : 5'd21;

    always_ff @(posedge clk)
        if (!reset) begin
            pending       <= '0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.stall_req <= 1'b0;
            starve        <= '0;
        end else begin
            pending   <= (pending & ~gnt) | press;
            bus.rf_we <= wb_win | flag_win;
            if (wb_win) begin
                bus.rf_waddr <= bus.wb_addr;
                bus.rf_wdata <= bus.wb_data;
            end else if (flag_win) begin
                bus.rf_waddr <= faddr;
                bus.rf_wdata <= 32'h0000_0001;
            end
            starve        <= (wb_win && |pending) ? ((starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1)) : '0;
            bus.stall_req <= wb_win && |pending && starve == SW'(STARVE_LIMIT - 1);
        end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with a run-length debounce and arbitration reference model
module tb_regfile_write_arbiter;
    localparam int D = 4;
    localparam int L = 8;

    logic       clk = 0, reset = 0, in_b = 0, dec_b = 0, out_b = 0;
    logic [2:0] pending;
    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.DEBOUNCE_CYCLES(D), .STARVE_LIMIT(L)) dut (
        .clk(clk), .reset(reset), .in_button(in_b), .decision_button(dec_b),
        .out_button(out_b), .bus(bus), .pending(pending)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, nwr = 0, nflag = 0, nstall = 0;
    bit chk_en = 0;
    logic [36:0] q[$];

    // reference model state
    logic [2:0] m_pend = 0, sy1 = 0, sy2 = 0, deb = 0;
    logic       m_stall = 0;
    int         waited = 0;
    int         run[3] = '{0, 0, 0};
    int         tgt[3] = '{22, 23, 21};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr();
        nwr = 0;
        nflag = 0;
        nstall = 0;
    endtask

    always @(posedge clk) begin
        logic [2:0] pb;
        logic       wbw, found;
        if (!reset) begin
            m_pend = 0; m_stall = 0; waited = 0; sy1 = 0; sy2 = 0; deb = 0;
            for (int b = 0; b < 3; b++) run[b] = 0;
        end else begin
            pb = m_pend;
            wbw = !m_stall && bus.wb_en && bus.wb_addr != 0;
            found = 0;
            if (wbw) q.push_back({bus.wb_addr, bus.wb_data});
            else
                for (int b = 0; b < 3; b++)
                    if (pb[b] && !found) begin
                        q.push_back({5'(tgt[b]), 32'd1});
                        m_pend[b] = 0;
                        found = 1;
                    end
            if (wbw && pb != 0) begin
                m_stall = (waited == L - 1);
                waited = (waited < L) ? waited + 1 : L;
            end else begin
                m_stall = 0;
                waited = 0;
            end
            for (int b = 0; b < 3; b++) begin
                run[b] = (sy2[b] != deb[b]) ? run[b] + 1 : 0;
                if (run[b] == D) begin
                    deb[b] = sy2[b];
                    run[b] = 0;
                    if (deb[b]) m_pend[b] = 1;
                end
            end
            sy2 = sy1;
            sy1 = {out_b, dec_b, in_b};
        end
    end

    always @(negedge clk)
        if (chk_en) begin
            logic [36:0] e;
            chk("pending", 32'(pending), 32'(m_pend));
            chk("stall_req", 32'(bus.stall_req), 32'(m_stall));
            chk("rf_we", 32'(bus.rf_we), 32'(q.size() != 0));
            if (bus.rf_we) begin
                nwr++;
                if (bus.rf_waddr inside {5'd21, 5'd22, 5'd23} && bus.rf_wdata == 32'd1) nflag++;
            end
            if (bus.stall_req) nstall++;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (bus.rf_we) begin
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(e[36:32]));
                    chk("rf_wdata", bus.rf_wdata, e[31:0]);
                end
            end
        end

    initial begin
        bus.wb_en = 0;
        bus.wb_addr = 0;
        bus.wb_data = 0;
        cyc(3);
        chk_en = 1;
        chk("reset_we", 32'(bus.rf_we), 0);
        chk("reset_waddr", 32'(bus.rf_waddr), 0);
        chk("reset_wdata", bus.rf_wdata, 0);
        chk("reset_stall", 32'(bus.stall_req), 0);
        chk("reset_pending", 32'(pending), 0);
        reset = 1;
        cyc(2);
        clr();
        in_b = 1;
        cyc(5);
        chk("press_not_yet", 32'(pending), 0);
        cyc(1);
        chk("press_pending", 32'(pending), 32'b001);
        cyc(1);
        chk("press_we", 32'(bus.rf_we), 1);
        chk("press_addr", 32'(bus.rf_waddr), 22);
        chk("press_data", bus.rf_wdata, 1);
        cyc(3);
        in_b = 0;
        cyc(20);
        chk("press_one_write", 32'(nwr), 1);
        clr();
        in_b = 1;
        cyc(2);
        in_b = 0;
        cyc(15);
        chk("glitch_pending", 32'(pending), 0);
        chk("glitch_writes", 32'(nwr), 0);
        clr();
        {in_b, dec_b, out_b} = 3'b111;
        cyc(10);
        {in_b, dec_b, out_b} = 3'b000;
        cyc(20);
        chk("all3_writes", 32'(nwr), 3);
        chk("all3_flags", 32'(nflag), 3);
        clr();
        bus.wb_en = 1;
        bus.wb_addr = 5;
        bus.wb_data = 32'hDEADBEEF;
        cyc(2);
        out_b = 1;
        cyc(10);
        out_b = 0;
        cyc(25);
        chk("starve_stalls", 32'(nstall), 1);
        chk("starve_flag", 32'(nflag), 1);
        bus.wb_en = 0;
        cyc(5);
        clr();
        bus.wb_en = 1;
        bus.wb_addr = 7;
        bus.wb_data = 32'h1234;
        dec_b = 1;
        cyc(8);
        bus.wb_addr = 0;
        cyc(1);
        chk("addr0_we", 32'(bus.rf_we), 1);
        chk("addr0_waddr", 32'(bus.rf_waddr), 23);
        chk("addr0_wdata", bus.rf_wdata, 1);
        dec_b = 0;
        bus.wb_en = 0;
        cyc(20);
        bus.wb_en = 1;
        bus.wb_addr = 9;
        in_b = 1;
        dec_b = 1;
        cyc(7);
        chk("prereset_pending", 32'(pending), 32'b011);
        reset = 0;
        in_b = 0;
        dec_b = 0;
        cyc(1);
        chk("midreset_pending", 32'(pending), 0);
        chk("midreset_we", 32'(bus.rf_we), 0);
        reset = 1;
        bus.wb_en = 0;
        clr();
        cyc(20);
        chk("postreset_writes", 32'(nwr), 0);
        for (int c = 0; c < 800; c++) begin
            int r;
            if ($urandom_range(0, 5) == 0) in_b = ~in_b;
            if ($urandom_range(0, 5) == 0) dec_b = ~dec_b;
            if ($urandom_range(0, 5) == 0) out_b = ~out_b;
            bus.wb_en = $urandom_range(0, 9) < 8;
            r = $urandom_range(0, 9);
            bus.wb_addr = (r < 2) ? 5'd0 : (r < 4) ? 5'(21 + $urandom_range(0, 2)) : 5'($urandom);
            bus.wb_data = $urandom;
            reset = $urandom_range(0, 119) != 0;
            cyc(1);
        end
        reset = 1;
        bus.wb_en = 0;
        {in_b, dec_b, out_b} = 3'b000;
        cyc(30);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
